boot_image_sequencer: RTL
=========================

Name: boot_image_sequencer

Overview:
- Parametrised successor to the top-level boot-ROM kickstart logic.
- Copies an image from a synchronous boot ROM into core memory through the core's download port (dn_go/dn_wr/dn_addr/dn_data), then pulses execute_enable.
- Adds beyond the current loader: configurable data/address width, ROM read latency, run-time length and destination base, dn_wait backpressure, explicit start, written-word count.
- Sits between boot_loader ROM and pcw_core, in clk_sys domain.

Parameters:
- AW, 16, address/length/count width.
- DW, 8, data width.
- LAT, 1, ROM read latency in cycles (1..3).
- AUTO_START, 1, 1 = start automatically on first cycle after reset deasserts.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a copy when IDLE.
- len  in  AW  words to copy; sampled at start.
- dst_base  in  AW  destination base address; sampled at start.
- exec_addr_in  in  AW  entry address; sampled at start.
- rom_addr  out  AW  ROM word index.
- rom_data  in  DW  ROM data, valid LAT cycles after rom_addr changes.
- dn_go  out  1  high while copying.
- dn_wr  out  1  write strobe.
- dn_addr  out  AW  write address.
- dn_data  out  DW  write data.
- dn_wait  in  1  backpressure; a write is accepted only when dn_wr=1 and dn_wait=0.
- execute_enable  out  1  one-cycle pulse at completion.
- execute_addr  out  AW  latched exec_addr_in; held until next start.
- count  out  AW  words accepted in current/last copy.

Behaviour:
- Reset (any state): state=IDLE; all outputs 0; latched len/base/exec cleared. No execute_enable for an aborted copy.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - A start trigger is start=1, or the first cycle with reset=0 after reset=1 when AUTO_START=1.
  - On a trigger: latch len, dst_base, exec_addr_in; index=0; count=0; rom_addr=0.
  - If len=0: go to DONE (dn_go stays 0). Else: go to FETCH with dn_go=1.
- FETCH:
  - Stay exactly LAT cycles; rom_addr stable.
  - On the last FETCH edge, register rom_data into dn_data; dn_addr = dst_base+index, mod 2^AW (wraps).
  - Then go to WRITE.
- WRITE:
  - dn_wr=1; dn_addr and dn_data held stable while dn_wait=1.
  - On acceptance: count+1.
  - If index = len-1: go to DONE, dn_wr=0.
  - Else: index+1, rom_addr+1, go to FETCH, dn_wr=0.
  - No duplicate writes; dn_wr never 1 outside WRITE.
- DONE: one cycle; dn_go=0, execute_enable=1, execute_addr valid; then IDLE.
- Throughput: LAT+1 cycles per word with dn_wait=0.
- First dn_wr is cycle LAT+1 after the trigger cycle.
- execute_enable comes 1 cycle after the last accepted write.
- With len=0, execute_enable comes 1 cycle after the trigger.
- start while not IDLE: ignored. Latched values do not change mid-copy.
- len = 2^AW-1 is legal; index never overflows.
- rom_addr starts at 0 and does not wrap within a copy.

Test Plan:
- AUTO_START=1, LAT=1, len=4, dst_base=0x0000, ROM 0xA0..0xA3, dn_wait=0, release reset at cycle 0 → dn_wr at cycles 2,4,6,8 with addr 0..3 and data A0..A3; execute_enable at cycle 9 only; count=4; dn_go high cycles 1..8.
- Same, dn_wait=1 for 3 cycles at the 2nd write → dn_wr/addr 0x0001/data A1 held 4 cycles; exactly 4 writes total; execute_enable delayed 3 cycles.
- AUTO_START=0, len=0, start pulse → dn_wr never 1; dn_go stays 0; execute_enable 1 cycle after start; count=0.
- dst_base=0xFFFE, len=4 → dn_addr FFFE, FFFF, 0000, 0001; rom_addr 0..3.
- reset asserted during 3rd word's FETCH → next edge all outputs 0, no execute_enable; AUTO_START=1 restarts from rom_addr 0 after release.
- LAT=3, len=2, start re-pulsed mid-copy → dn_wr every 4 cycles; second start ignored; execute_addr = first-sampled exec_addr_in (e.g. 0x0100).

Source files
------------

// File: rtl/boot_image_sequencer.sv
// boot_image_sequencer
// Copies an image from a synchronous boot ROM into core memory through the
// core's download port, then pulses execute_enable with the latched entry
// address. Runs in the clk_sys domain between the boot ROM and the core.
//
// Ports:
//   clk_sys        system clock
//   reset          synchronous, active-high reset
//   start          pulse; begins a copy when idle
//   len            words to copy (sampled at start)
//   dst_base       destination base address (sampled at start)
//   exec_addr_in   entry address (sampled at start)
//   rom_addr       ROM word index
//   rom_data       ROM data, valid LAT cycles after rom_addr changes
//   dn_go          high while copying
//   dn_wr          write strobe
//   dn_addr        write address
//   dn_data        write data
//   dn_wait        backpressure; write accepted when dn_wr=1 and dn_wait=0
//   execute_enable one-cycle pulse at completion
//   execute_addr   latched entry address, held until the next start
//   count          words accepted in the current/last copy
module boot_image_sequencer #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int LAT        = 1,
    parameter int AUTO_START = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic [AW-1:0] dst_base,
    input  logic [AW-1:0] exec_addr_in,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          dn_go,
    output logic          dn_wr,
    output logic [AW-1:0] dn_addr,
    output logic [DW-1:0] dn_data,
    input  logic          dn_wait,
    output logic          execute_enable,
    output logic [AW-1:0] execute_addr,
    output logic [AW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    LAT_LAST = 2'(LAT - 1);
    localparam logic          AUTO_BIT = (AUTO_START != 0);

    state_t        state_r, state_nxt;
    logic [AW-1:0] rom_addr_r, rom_addr_nxt;   // doubles as the word index
    logic [AW-1:0] len_r, len_nxt;
    logic [AW-1:0] base_r, base_nxt;
    logic [AW-1:0] exec_addr_r, exec_addr_nxt;
    logic [AW-1:0] count_r, count_nxt;
    logic [AW-1:0] dn_addr_r, dn_addr_nxt;
    logic [DW-1:0] dn_data_r, dn_data_nxt;
    logic [1:0]    fetch_cnt_r, fetch_cnt_nxt;
    logic          dn_go_r, dn_go_nxt;
    logic          dn_wr_r, dn_wr_nxt;
    logic          exec_en_r, exec_en_nxt;
    logic          auto_pend_r, auto_pend_nxt;   // set only for the first cycle out of reset

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r     <= IDLE;
            rom_addr_r  <= ZERO;
            len_r       <= ZERO;
            base_r      <= ZERO;
            exec_addr_r <= ZERO;
            count_r     <= ZERO;
            dn_addr_r   <= ZERO;
            dn_data_r   <= {DW{1'b0}};
            fetch_cnt_r <= 2'd0;
            dn_go_r     <= 1'b0;
            dn_wr_r     <= 1'b0;
            exec_en_r   <= 1'b0;
            auto_pend_r <= AUTO_BIT;
        end else begin
            state_r     <= state_nxt;
            rom_addr_r  <= rom_addr_nxt;
            len_r       <= len_nxt;
            base_r      <= base_nxt;
            exec_addr_r <= exec_addr_nxt;
            count_r     <= count_nxt;
            dn_addr_r   <= dn_addr_nxt;
            dn_data_r   <= dn_data_nxt;
            fetch_cnt_r <= fetch_cnt_nxt;
            dn_go_r     <= dn_go_nxt;
            dn_wr_r     <= dn_wr_nxt;
            exec_en_r   <= exec_en_nxt;
            auto_pend_r <= auto_pend_nxt;
        end
    end

    // Next-state and next-output logic; outputs are registered so each
    // transition sets the values the next state must present
    always_comb begin
        state_nxt     = state_r;
        rom_addr_nxt  = rom_addr_r;
        len_nxt       = len_r;
        base_nxt      = base_r;
        exec_addr_nxt = exec_addr_r;
        count_nxt     = count_r;
        dn_addr_nxt   = dn_addr_r;
        dn_data_nxt   = dn_data_r;
        fetch_cnt_nxt = fetch_cnt_r;
        dn_go_nxt     = dn_go_r;
        dn_wr_nxt     = dn_wr_r;
        exec_en_nxt   = 1'b0;
        auto_pend_nxt = 1'b0;

        case (state_r)
            IDLE: begin
                if (start || auto_pend_r) begin
                    len_nxt       = len;
                    base_nxt      = dst_base;
                    exec_addr_nxt = exec_addr_in;
                    rom_addr_nxt  = ZERO;
                    count_nxt     = ZERO;
                    fetch_cnt_nxt = 2'd0;
                    if (len == ZERO) begin
                        // Empty image: go straight to the completion pulse
                        state_nxt   = DONE;
                        dn_go_nxt   = 1'b0;
                        exec_en_nxt = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                        dn_go_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (fetch_cnt_r == LAT_LAST) begin
                    // ROM output has settled for the current index
                    dn_data_nxt   = rom_data;
                    dn_addr_nxt   = base_r + rom_addr_r;
                    dn_wr_nxt     = 1'b1;
                    fetch_cnt_nxt = 2'd0;
                    state_nxt     = WRITE;
                end else begin
                    fetch_cnt_nxt = fetch_cnt_r + 2'd1;
                end
            end
            WRITE: begin
                if (!dn_wait) begin
                    count_nxt = count_r + ONE;
                    dn_wr_nxt = 1'b0;
                    // Compare against len-1 so a full 2^AW-1 image never overflows the index
                    if (rom_addr_r == len_r - ONE) begin
                        state_nxt   = DONE;
                        dn_go_nxt   = 1'b0;
                        exec_en_nxt = 1'b1;
                    end else begin
                        rom_addr_nxt = rom_addr_r + ONE;
                        state_nxt    = FETCH;
                    end
                end else begin
                    dn_wr_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rom_addr       = rom_addr_r;
    assign dn_go          = dn_go_r;
    assign dn_wr          = dn_wr_r;
    assign dn_addr        = dn_addr_r;
    assign dn_data        = dn_data_r;
    assign execute_enable = exec_en_r;
    assign execute_addr   = exec_addr_r;
    assign count          = count_r;

endmodule
